// File: rtl/fir_sample_feeder.sv
// Purpose: buffers source samples in a FIFO and issues them one at a time to the FIR (optional FEEDER_OVERFLOW_CNT_EN adds drop_count).
// Latency: a write into an empty idle FIFO pops on the next edge; fir_input_valid pulses for one cycle after that pop.
// Backpressure: in_ready drops while the FIFO is full; writes refused while full are dropped and flagged in overflow.
module fir_sample_feeder #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     in_ready,
    output logic                     fir_input_valid,
    output logic [DATA_W-1:0]        fir_data,
    input  logic                     fir_output_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     overflow_clr,
`ifdef FEEDER_OVERFLOW_CNT_EN
    output logic [15:0]              drop_count,
`endif
    output logic                     timeout_err
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int WD_W   = $clog2(TIMEOUT);
    localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [WD_W-1:0]     wdog;
    logic                wr_en;
    logic                drop;
    logic                pop;
    logic                wd_expired;

    assign in_ready   = (level != LVL_FULL);
    assign wr_en      = in_valid & in_ready;
    assign drop       = in_valid & ~in_ready;
    assign pop        = (state == IDLE) && (level != '0);
    assign wd_expired = (wdog == WD_LAST);

    // Storage is deliberately left unreset; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
`ifdef FEEDER_OVERFLOW_CNT_EN
            drop_count <= '0;
`endif
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (overflow_clr) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
`ifdef FEEDER_OVERFLOW_CNT_EN
            if (overflow_clr) begin
                drop_count <= '0;
            end else if (drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rd_ptr          <= '0;
            fir_data        <= '0;
            fir_input_valid <= 1'b0;
            busy            <= 1'b0;
            wdog            <= '0;
            timeout_err     <= 1'b0;
        end else begin
            fir_input_valid <= 1'b0;
            if (overflow_clr) begin
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (pop) begin
                        fir_data        <= mem[rd_ptr];
                        rd_ptr          <= rd_ptr + 1'b1;
                        fir_input_valid <= 1'b1;
                        busy            <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (fir_output_valid) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wd_expired) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                        if (!overflow_clr) begin
                            timeout_err <= 1'b1;
                        end
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
